craft_decrypt: RTL and testbench
================================

Name: craft_decrypt

Overview:
- Iterative CRAFT decryption core: 64-bit block, 64-bit tweak, 128-bit key, one round step per clock.
- Inverse counterpart of craft_encrypt. Recovers the plaintext from a ciphertext produced by craft_encrypt under the same key and tweak.
- Sits beside craft_encrypt under the board top level. Start/busy/done handshake.

Parameters:
- ROUNDS, 32: number of cipher rounds to invert. Legal range 2..32; 32 is full CRAFT. Reduced values are for cryptanalysis builds only.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  request; sampled only while busy=0
- ciphertext  input  64  block to decrypt; nibble 0 = bits [63:60]
- tweak  input  64  tweak T
- key  input  128  K0 = key[127:64], K1 = key[63:0]
- busy  output  1  high while rounds are in progress
- done  output  1  one-cycle pulse; plaintext valid
- plaintext  output  64  result; holds until the next completion or reset

Behaviour:
- Reset (rst=1 at an edge): busy=0, done=0, plaintext=0, round counter=0, state register=0.
  - Reset has priority over everything, including mid-operation. The aborted job never raises done.
- Tweakeys:
  - TK0 = K0^T, TK1 = K1^T, TK2 = K0^Q(T), TK3 = K1^Q(T).
  - Q nibble permutation (out[i]=in[Q[i]]): 12,10,15,5,14,8,9,2,11,3,7,4,6,0,1,13.
- Round constants RC_r:
  - 8 bits, a_r in the high hex digit, b_r in the low hex digit.
  - Sequence for r=0..14: 11,84,42,25,96,C7,63,B1,54,A2,D5,E6,F7,73,31, repeating with period 15.
  - RC_r XORs a_r into nibble 4 and b_r (3 bits, zero-extended) into nibble 5.
  - c_r = RC_r ^ TK_(r mod 4).
  - Backward LFSR or table implementation is free; the values above are normative.
- Primitives:
  - MC: row0 ^= row2^row3 and row1 ^= row3, computed from the original values. Nibble i is in row i/4, column i%4.
  - PN (out[i]=in[P[i]]): 15,12,13,14,10,9,8,11,6,5,4,7,1,2,3,0.
  - SB nibble S-box: C,A,D,3,E,B,F,7,8,9,1,5,0,2,4,6.
  - PN and SB are both involutions.
- Step function, with x the state register:
  - Step 0: x <= MC(x ^ c_(ROUNDS-1)).
  - Step k, k=1..ROUNDS-1: x <= MC(PN(SB(x)) ^ c_(ROUNDS-1-k)).
- FSM IDLE/RUN:
  - IDLE and start=1 at edge t: x <= ciphertext, counter <= 0, busy <= 1, state <= RUN.
  - RUN: one step per edge, counter increments.
  - At edge t+ROUNDS: plaintext <= result of the last step, done <= 1, busy <= 0, state <= IDLE.
  - Latency is ROUNDS edges from the accepted start to done visible; 32 for a full-round build.
- done is high for exactly one cycle; otherwise 0.
- start while busy=1 is ignored, with no queuing.
- start in the same cycle done is high is accepted, giving back-to-back jobs with no bubble.
- start held high continuously gives a new job every ROUNDS+1 cycles.
- ciphertext is sampled only at acceptance.
- Without the optional feature, key and tweak must stay stable while busy=1. Changing them gives an undefined result but must not hang the FSM.

Optional Feature:
- Macro CRAFT_DEC_KEY_LATCH_EN.
- Defined:
  - key and tweak are registered at the accepted start. The four tweakeys are precomputed into a 256-bit register in the same cycle.
  - Input changes during busy have no effect on the result.
  - Latency and handshake are unchanged.
- Undefined:
  - Tweakeys are derived combinationally from the live inputs each cycle. No extra registers.
  - Inputs must be held while busy.

Test Plan:
- Reset, then idle 5 cycles -> busy=0, done=0, plaintext=64'h0.
- Key 27A6781A43F364BC916708D5FBB5AEFE, tweak 54CD94FFD0670A58. Feed craft_encrypt's ciphertext of 5734F006D8D88A3E, pulse start -> done exactly 32 cycles later, plaintext=5734F006D8D88A3E, busy low after done.
- Same vector with start held high for 70 cycles -> exactly two done pulses, 33 cycles apart, both with plaintext=5734F006D8D88A3E. Start pulses during busy produce no extra jobs.
- rst asserted at round 15 -> busy=0, plaintext=0, no done. Then a fresh start -> correct result after 32 cycles.
- CRAFT_DEC_KEY_LATCH_EN defined: flip key to all-ones at round 10 -> plaintext still 5734F006D8D88A3E.
- 1000 random key/tweak/plaintext triples encrypted by craft_encrypt -> decryption matches the original every time.

Source files
------------

// File: rtl/craft_decrypt.sv
// -----------------------------------------------------------------------------
// craft_decrypt
//
// Iterative CRAFT decryption core: 64-bit block, 64-bit tweak, 128-bit key.
// One inverse round step is performed per clock edge, so a full-round build
// returns the plaintext ROUNDS edges after the start is accepted.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous reset, active-high, priority over everything
//   start       job request, only looked at while busy=0
//   ciphertext  block to decrypt (nibble 0 = bits [63:60])
//   tweak       tweak T
//   key         K0 = key[127:64], K1 = key[63:0]
//   busy        high while rounds are in progress
//   done        one-cycle pulse, plaintext valid
//   plaintext   result, held until the next completion or reset
//
// Parameter:
//   ROUNDS      number of rounds to invert, 2..32 (32 = full CRAFT)
//
// Optional feature macro: CRAFT_DEC_KEY_LATCH_EN
//   Defined   : the four tweakeys are captured into a 256-bit register when a
//               job is accepted, so key/tweak may change while busy.
//   Undefined : tweakeys come combinationally from the live key/tweak inputs,
//               which must then be held stable while busy.
// -----------------------------------------------------------------------------
module craft_decrypt #(
   parameter int ROUNDS = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [63:0]  ciphertext,
   input  logic [63:0]  tweak,
   input  logic [127:0] key,
   output logic         busy,
   output logic         done,
   output logic [63:0]  plaintext
);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   // Nibble i of each table holds entry i (nibble 0 in the top four bits).
   localparam logic [63:0] P_TABLE = 64'hFCDEA98B65471230;
   localparam logic [63:0] Q_TABLE = 64'hCAF5E892B374601D;
   localparam logic [63:0] S_TABLE = 64'hCAD3EBF789150246;
   localparam logic [5:0]  LAST_STEP = 6'(ROUNDS - 1);

   state_t        state;
   logic [63:0]   x;
   logic [5:0]    counter;

   logic [63:0]   q_tweak;
   logic [255:0]  tk_live;
   logic [255:0]  tk_use;
   logic [5:0]    round_idx;
   logic [3:0]    rc_idx;
   logic [7:0]    rc_byte;
   logic [63:0]   tk_sel;
   logic [63:0]   round_const;
   logic [63:0]   step_in;
   logic [63:0]   step_out;

   // out[i] = in[tbl[i]] on nibbles
   function automatic logic [63:0] nib_perm(input logic [63:0] v, input logic [63:0] tbl);
      logic [63:0] r;
      int          src;
      r = '0;
      for (int i = 0; i < 16; i++) begin
         src = int'(tbl[63-4*i -: 4]);
         r[63-4*i -: 4] = v[63-4*src -: 4];
      end
      return r;
   endfunction

   function automatic logic [63:0] sub_nibbles(input logic [63:0] v);
      logic [63:0] r;
      int          idx;
      r = '0;
      for (int i = 0; i < 16; i++) begin
         idx = int'(v[63-4*i -: 4]);
         r[63-4*i -: 4] = S_TABLE[63-4*idx -: 4];
      end
      return r;
   endfunction

   // Rows are 16-bit slices; MC is its own inverse, so it serves decryption
   function automatic logic [63:0] mix_columns(input logic [63:0] v);
      return {v[63:48] ^ v[31:16] ^ v[15:0],
              v[47:32] ^ v[15:0],
              v[31:16],
              v[15:0]};
   endfunction

   // The low digit of every constant is at most 7, so its 4-bit value equals
   // the 3-bit b_r zero-extended.
   function automatic logic [7:0] rc_lookup(input logic [3:0] idx);
      logic [7:0] r;
      case (idx)
         4'd0:    r = 8'h11;
         4'd1:    r = 8'h84;
         4'd2:    r = 8'h42;
         4'd3:    r = 8'h25;
         4'd4:    r = 8'h96;
         4'd5:    r = 8'hC7;
         4'd6:    r = 8'h63;
         4'd7:    r = 8'hB1;
         4'd8:    r = 8'h54;
         4'd9:    r = 8'hA2;
         4'd10:   r = 8'hD5;
         4'd11:   r = 8'hE6;
         4'd12:   r = 8'hF7;
         4'd13:   r = 8'h73;
         4'd14:   r = 8'h31;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   // Live tweakeys TK0..TK3, packed with TK0 in the top 64 bits.
   always_comb begin
      q_tweak = nib_perm(tweak, Q_TABLE);
      tk_live = {key[127:64] ^ tweak, key[63:0] ^ tweak,
                 key[127:64] ^ q_tweak, key[63:0] ^ q_tweak};
   end

`ifdef CRAFT_DEC_KEY_LATCH_EN
   logic [255:0] tk_reg;

   // Capture the tweakeys together with the ciphertext so later input
   // changes cannot disturb a running job.
   always_ff @(posedge clk) begin
      if (rst) begin
         tk_reg <= '0;
      end else if (state == IDLE && start) begin
         tk_reg <= tk_live;
      end
   end

   assign tk_use = tk_reg;
`else
   assign tk_use = tk_live;
`endif

   // One inverse round. Steps run the encryption rounds backwards, so the
   // round index counts down from ROUNDS-1. Step 0 undoes the final
   // encryption round, which has no PN/SB layer.
   always_comb begin
      round_idx = LAST_STEP - counter;
      rc_idx    = 4'(round_idx % 6'd15);
      rc_byte   = rc_lookup(rc_idx);
      case (round_idx[1:0])
         2'd0:    tk_sel = tk_use[255:192];
         2'd1:    tk_sel = tk_use[191:128];
         2'd2:    tk_sel = tk_use[127:64];
         default: tk_sel = tk_use[63:0];
      endcase
      round_const = tk_sel ^ {16'h0000, rc_byte[7:4], rc_byte[3:0], 40'h0};
      step_in     = (counter == 6'd0) ? x : nib_perm(sub_nibbles(x), P_TABLE);
      step_out    = mix_columns(step_in ^ round_const);
   end

   // IDLE/RUN control. A job accepted at edge t completes at edge t+ROUNDS;
   // the FSM is back in IDLE while done is high, so a start in that cycle is
   // taken on the very next edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         x         <= '0;
         counter   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         plaintext <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  x       <= ciphertext;
                  counter <= '0;
                  busy    <= 1'b1;
                  state   <= RUN;
               end
            end
            RUN: begin
               if (counter == LAST_STEP) begin
                  plaintext <= step_out;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end else begin
                  x       <= step_out;
                  counter <= counter + 6'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_craft_decrypt.sv
// -----------------------------------------------------------------------------
// tb_craft_decrypt
//
// Bench for craft_decrypt. A nibble-array CRAFT encryption model produces
// ciphertexts; the DUT must turn them back into the original plaintexts with
// the documented latency and handshake.
// -----------------------------------------------------------------------------
module tb_craft_decrypt;

   localparam int NR = 32;

   logic         clk;
   logic         rst;
   logic         start;
   logic [63:0]  ciphertext;
   logic [63:0]  tweak;
   logic [127:0] key;
   logic         busy;
   logic         done;
   logic [63:0]  plaintext;

   int total = 0;
   int bad   = 0;

   int p_tab[16]  = '{15, 12, 13, 14, 10, 9, 8, 11, 6, 5, 4, 7, 1, 2, 3, 0};
   int q_tab[16]  = '{12, 10, 15, 5, 14, 8, 9, 2, 11, 3, 7, 4, 6, 0, 1, 13};
   int s_tab[16]  = '{12, 10, 13, 3, 14, 11, 15, 7, 8, 9, 1, 5, 0, 2, 4, 6};
   int rc_tab[15] = '{'h11, 'h84, 'h42, 'h25, 'h96, 'hC7, 'h63, 'hB1,
                      'h54, 'hA2, 'hD5, 'hE6, 'hF7, 'h73, 'h31};

   localparam logic [127:0] KAT_KEY   = 128'h27A6781A43F364BC916708D5FBB5AEFE;
   localparam logic [63:0]  KAT_TWEAK = 64'h54CD94FFD0670A58;
   localparam logic [63:0]  KAT_PT    = 64'h5734F006D8D88A3E;

   logic [63:0] kat_ct;

   craft_decrypt #(.ROUNDS(NR)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .ciphertext (ciphertext),
      .tweak      (tweak),
      .key        (key),
      .busy       (busy),
      .done       (done),
      .plaintext  (plaintext)
   );

   // 100 MHz clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Forward CRAFT on a state held as 16 nibble integers
   function automatic logic [63:0] craft_enc(input logic [63:0] p, input logic [127:0] k,
                                             input logic [63:0] t);
      int s[16];
      int tmp[16];
      int tn[16];
      int k0[16];
      int k1[16];
      int tk[4][16];
      int rc;
      logic [63:0] out;
      for (int i = 0; i < 16; i++) begin
         s[i]  = int'(p[63-4*i -: 4]);
         tn[i] = int'(t[63-4*i -: 4]);
         k0[i] = int'(k[127-4*i -: 4]);
         k1[i] = int'(k[63-4*i -: 4]);
      end
      for (int i = 0; i < 16; i++) begin
         tk[0][i] = k0[i] ^ tn[i];
         tk[1][i] = k1[i] ^ tn[i];
         tk[2][i] = k0[i] ^ tn[q_tab[i]];
         tk[3][i] = k1[i] ^ tn[q_tab[i]];
      end
      for (int r = 0; r < NR; r++) begin
         for (int c = 0; c < 4; c++) begin
            s[c]     = s[c] ^ s[8+c] ^ s[12+c];
            s[4+c]   = s[4+c] ^ s[12+c];
         end
         rc   = rc_tab[r % 15];
         s[4] = s[4] ^ (rc / 16);
         s[5] = s[5] ^ (rc % 8);
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ tk[r % 4][i];
         if (r != NR - 1) begin
            for (int i = 0; i < 16; i++) tmp[i] = s[p_tab[i]];
            for (int i = 0; i < 16; i++) s[i] = s_tab[tmp[i]];
         end
      end
      out = '0;
      for (int i = 0; i < 16; i++) out[63-4*i -: 4] = 4'(s[i]);
      return out;
   endfunction

   // Single comparison point for the whole bench
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Run one job; lat = edges from acceptance to done visible, -1 on timeout
   task automatic applyStimulus(input logic [63:0] ct, input logic [127:0] k,
                                input logic [63:0] t, output int lat,
                                output logic [63:0] result);
      @(negedge clk);
      ciphertext = ct;
      key        = k;
      tweak      = t;
      start      = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
      lat    = -1;
      result = '0;
      for (int n = 1; n <= 100; n++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat    = n;
            result = plaintext;
            break;
         end
      end
   endtask

   // Bounded wait for the DUT to return to idle
   task automatic waitIdle(input string tag);
      int n;
      n = 0;
      while (busy && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput(tag, 64'(busy), 64'd0);
   endtask

   initial begin
      int          lat;
      int          cnt;
      int          first_at;
      int          second_at;
      logic [63:0] res;
      logic [63:0] res1;
      logic [63:0] res2;
      logic [63:0] pt;
      logic [127:0] k;
      logic [63:0] t;

      rst        = 1'b1;
      start      = 1'b0;
      ciphertext = '0;
      tweak      = '0;
      key        = '0;
      kat_ct     = craft_enc(KAT_PT, KAT_KEY, KAT_TWEAK);

      // Reset state after a few idle cycles
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      checkOutput("reset_busy", 64'(busy), 64'd0);
      checkOutput("reset_done", 64'(done), 64'd0);
      checkOutput("reset_pt", plaintext, 64'd0);

      // Known-answer job
      applyStimulus(kat_ct, KAT_KEY, KAT_TWEAK, lat, res);
      checkOutput("kat_latency", 64'(lat), 64'd32);
      checkOutput("kat_pt", res, KAT_PT);
      checkOutput("kat_busy_at_done", 64'(busy), 64'd0);
      @(posedge clk);
      #1;
      checkOutput("kat_done_pulse", 64'(done), 64'd0);
      checkOutput("kat_pt_hold", plaintext, KAT_PT);

      // Start pulse during busy must be ignored, no queued job afterwards
      @(negedge clk);
      ciphertext = kat_ct;
      start      = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      checkOutput("busy_running", 64'(busy), 64'd1);
      lat = -1;
      res = '0;
      for (int n = 1; n <= 100; n++) begin
         @(posedge clk);
         #1;
         start = (n == 5);
         if (n == 5) ciphertext = ~kat_ct;
         if (done) begin
            lat = n;
            res = plaintext;
            break;
         end
      end
      start = 1'b0;
      checkOutput("ignore_latency", 64'(lat), 64'd32);
      checkOutput("ignore_pt", res, KAT_PT);
      cnt = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done || busy) cnt++;
      end
      checkOutput("no_queued_job", 64'(cnt), 64'd0);

      // Start held high for 70 cycles
      @(negedge clk);
      ciphertext = kat_ct;
      start      = 1'b1;
      cnt        = 0;
      first_at   = -1;
      second_at  = -1;
      res1       = '0;
      res2       = '0;
      for (int n = 1; n <= 70; n++) begin
         @(posedge clk);
         #1;
         if (done) begin
            cnt++;
            if (cnt == 1) begin
               first_at = n;
               res1     = plaintext;
            end else if (cnt == 2) begin
               second_at = n;
               res2      = plaintext;
            end
         end
      end
      start = 1'b0;
      checkOutput("held_done_count", 64'(cnt), 64'd2);
      checkOutput("held_first_at", 64'(first_at), 64'd33);
      checkOutput("held_gap", 64'(second_at - first_at), 64'd33);
      checkOutput("held_pt1", res1, KAT_PT);
      checkOutput("held_pt2", res2, KAT_PT);
      waitIdle("held_drain");

      // Reset in the middle of a job
      @(negedge clk);
      ciphertext = kat_ct;
      start      = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("abort_busy", 64'(busy), 64'd0);
      checkOutput("abort_done", 64'(done), 64'd0);
      checkOutput("abort_pt", plaintext, 64'd0);
      cnt = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done) cnt++;
      end
      checkOutput("abort_no_done", 64'(cnt), 64'd0);
      applyStimulus(kat_ct, KAT_KEY, KAT_TWEAK, lat, res);
      checkOutput("after_abort_latency", 64'(lat), 64'd32);
      checkOutput("after_abort_pt", res, KAT_PT);

`ifdef CRAFT_DEC_KEY_LATCH_EN
      // Key and tweak disturbed mid-job must not affect the result
      @(negedge clk);
      ciphertext = kat_ct;
      key        = KAT_KEY;
      tweak      = KAT_TWEAK;
      start      = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat   = -1;
      res   = '0;
      for (int n = 1; n <= 100; n++) begin
         @(posedge clk);
         #1;
         if (n == 10) begin
            key   = '1;
            tweak = ~KAT_TWEAK;
         end
         if (done) begin
            lat = n;
            res = plaintext;
            break;
         end
      end
      checkOutput("latch_latency", 64'(lat), 64'd32);
      checkOutput("latch_pt", res, KAT_PT);
`endif

      // Random key/tweak/plaintext triples
      for (int i = 0; i < 1000; i++) begin
         pt = {$urandom, $urandom};
         k  = {$urandom, $urandom, $urandom, $urandom};
         t  = {$urandom, $urandom};
         applyStimulus(craft_enc(pt, k, t), k, t, lat, res);
         checkOutput($sformatf("rand_%0d", i), res, pt);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
